// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, up to BURST writes per grant.
// Latency: first write one cycle after arbitration; backpressure: fifo_full stalls the burst without ending it.
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       grant,
  input  logic                  fifo_full,
  output logic                  fifo_wen,
  output logic [WIDTH-1:0]      fifo_din
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_last;
  logic [CW-1:0] r_cnt;

  logic          w_pick_vld;
  logic [IW-1:0] w_pick_idx;
  logic          w_own_req;
  logic          w_wen;
  int            w_t;

  // Walk from last+NREQ down to last+1 so the nearest requester after last wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_t        = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_t = int'(r_last) + k;
      if (w_t >= NREQ) w_t = w_t - NREQ;
      if (req[w_t]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = IW'(w_t);
      end
    end
  end

  assign w_own_req = req[r_owner];
  assign w_wen     = (r_state == S_GRANT) && w_own_req && !fifo_full;
  assign fifo_wen  = w_wen;

  always_comb begin
    grant    = '0;
    fifo_din = '0;
    if (r_state == S_GRANT) begin
      grant[r_owner] = 1'b1;
      fifo_din       = din[r_owner*WIDTH +: WIDTH];
    end
  end

  assign ack = grant & {NREQ{w_wen}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= IW'(NREQ - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_owner <= w_pick_idx;
            r_last  <= w_pick_idx;
            r_cnt   <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_own_req) begin
            r_state <= S_IDLE;
          end else if (w_wen) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(BURST - 1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter plus randomized invariant and starvation checks.
module tb_fifo_wr_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;
  // Counts the cycle the request rises in, hence one above (N-1)*(B+1).
  localparam int STARVE_LIMIT = (N - 1) * (B + 1) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] din;
  logic [N-1:0] ack;
  logic [N-1:0] grant;
  logic         fifo_full;
  logic         fifo_wen;
  logic [W-1:0] fifo_din;

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .grant(grant),
    .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_din(fifo_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           c;
    logic [N-1:0] a;
    logic [W-1:0] d;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit sb_on = 0;
  bit starve_on = 0;
  logic [N-1:0] ack_s = '0;
  int wait_c[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic set_din(input int i, input logic [W-1:0] v);
    din[i*W +: W] = v;
  endtask

  task automatic push_burst(input int first_c, input int idx, input logic [W-1:0] d, input int nw);
    exp_t e;
    for (int j = 0; j < nw; j++) begin
      e.c = first_c + j;
      e.a = '0;
      e.a[idx] = 1'b1;
      e.d = d;
      q.push_back(e);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pops on each write.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    check("no_wen_when_full", 64'(fifo_wen & fifo_full), 64'd0);
    check("ack_onehot0", 64'($onehot0(ack)), 64'd1);
    check("ack_matches_wen", 64'(|ack), 64'(fifo_wen));
    check("ack_within_grant", 64'(ack & ~grant), 64'd0);
    if (fifo_wen) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      check("fifo_din_slice", 64'(fifo_din), 64'(din[idx*W +: W]));
    end
    if (sb_on) begin
      if (fifo_wen) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: ack %0h data %0h at cycle %0d, none expected", ack, fifo_din, cyc);
        end else begin
          e = q.pop_front();
          check("write_cycle", 64'(cyc), 64'(e.c));
          check("write_ack", 64'(ack), 64'(e.a));
          check("write_data", 64'(fifo_din), 64'(e.d));
        end
      end else if (q.size() != 0 && q[0].c <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_write: no write at cycle %0d, expected ack %0h data %0h", e.c, e.a, e.d);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (starve_on && !rst && req[i] && !ack[i]) begin
        wait_c[i]++;
        check("starvation_bound", 64'(wait_c[i] > STARVE_LIMIT), 64'd0);
      end else begin
        wait_c[i] = 0;
      end
    end
    ack_s = ack;
  end

  initial begin
    int base;
    int base2;
    rst = 1'b1; req = '0; din = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    tick(2);
    req = '1; din = 32'hDEADBEEF; fifo_full = 1'b0;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_wen", 64'(fifo_wen), 64'd0);
    check("rst_fifo_din", 64'(fifo_din), 64'd0);
    tick(1);
    check("rst_grant_held", 64'(grant), 64'd0);

    // A: single producer, bursts of 4 with one idle cycle between re-grants.
    rst = 1'b0; req = 4'b0001; din = '0; set_din(0, 8'hA5);
    base = cyc; sb_on = 1;
    push_burst(base + 1, 0, 8'hA5, 4);
    push_burst(base + 6, 0, 8'hA5, 1);
    #1 check("A_idle_grant", 64'(grant), 64'd0);
    goto(base + 1); #1 check("A_grant_c1", 64'(grant), 64'h1);
    goto(base + 5); #1 check("A_gap_grant", 64'(grant), 64'd0);
    goto(base + 6); #1 check("A_regrant", 64'(grant), 64'h1);
    goto(base + 7); req = '0;
    tick(3);
    check("A_drained", 64'(q.size()), 64'd0);

    // B: all request, round-robin 0,1,2,3,0.
    rst = 1'b1; tick(2);
    rst = 1'b0; req = 4'b1111; din = {8'h44, 8'h33, 8'h22, 8'h11};
    base = cyc;
    push_burst(base + 1,  0, 8'h11, 4);
    push_burst(base + 6,  1, 8'h22, 4);
    push_burst(base + 11, 2, 8'h33, 4);
    push_burst(base + 16, 3, 8'h44, 4);
    push_burst(base + 21, 0, 8'h11, 4);
    goto(base + 6);  #1 check("B_grant1", 64'(grant), 64'h2);
    goto(base + 15); #1 check("B_gap", 64'(grant), 64'd0);
    goto(base + 16); #1 check("B_grant3", 64'(grant), 64'h8);
    goto(base + 21); #1 check("B_grant0_again", 64'(grant), 64'h1);
    goto(base + 25); req = '0;
    tick(3);
    check("B_drained", 64'(q.size()), 64'd0);

    // C: owner 2 stalled by a full FIFO for three cycles mid-burst.
    rst = 1'b1; tick(2);
    rst = 1'b0; req = 4'b0100; din = '0; set_din(2, 8'hC3);
    base = cyc;
    push_burst(base + 1, 2, 8'hC3, 2);
    push_burst(base + 6, 2, 8'hC3, 2);
    goto(base + 3); fifo_full = 1'b1;
    #1 check("C_full_grant_held", 64'(grant), 64'h4);
    goto(base + 5); #1 check("C_full_grant_held2", 64'(grant), 64'h4);
    goto(base + 6); fifo_full = 1'b0;
    goto(base + 8); req = '0;
    #1 check("C_idle_after_burst", 64'(grant), 64'd0);
    tick(3);
    check("C_drained", 64'(q.size()), 64'd0);

    // D: owner 1 drops after two writes; next pick starts after 1, skipping 2.
    rst = 1'b1; tick(2);
    rst = 1'b0; req = 4'b0010; din = '0;
    set_din(0, 8'h44); set_din(1, 8'h11); set_din(3, 8'h33);
    base = cyc;
    push_burst(base + 1, 1, 8'h11, 2);
    push_burst(base + 5, 3, 8'h33, 4);
    goto(base + 2); req = 4'b0011;
    goto(base + 3); req = 4'b1001;
    #1 check("D_grant_after_drop", 64'(grant), 64'h2);
    goto(base + 4); #1 check("D_idle", 64'(grant), 64'd0);
    goto(base + 5); #1 check("D_grant3", 64'(grant), 64'h8);
    goto(base + 9); req = '0;
    tick(3);
    check("D_drained", 64'(q.size()), 64'd0);

    // E: asynchronous reset mid-burst, then producer 3 wins on the first edge.
    rst = 1'b1; tick(2);
    rst = 1'b0; req = 4'b0001; din = '0; set_din(0, 8'h5A);
    base = cyc;
    push_burst(base + 1, 0, 8'h5A, 2);
    goto(base + 3);
    #1 check("E_wen_before_rst", 64'(fifo_wen), 64'd1);
    rst = 1'b1;
    #1;
    check("E_abort_wen", 64'(fifo_wen), 64'd0);
    check("E_abort_ack", 64'(ack), 64'd0);
    check("E_abort_grant", 64'(grant), 64'd0);
    check("E_abort_din", 64'(fifo_din), 64'd0);
    req = 4'b1000; set_din(3, 8'h77);
    tick(1);
    rst = 1'b0;
    base2 = cyc;
    push_burst(base2 + 1, 3, 8'h77, 4);
    goto(base2 + 1); #1 check("E_grant3_first_edge", 64'(grant), 64'h8);
    goto(base2 + 5); req = '0;
    tick(3);
    check("E_drained", 64'(q.size()), 64'd0);
    sb_on = 0;

    // Random, FIFO never full: starvation bound enforced.
    rst = 1'b1; tick(2);
    rst = 1'b0; starve_on = 1;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack_s[i] && $urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
        set_din(i, W'($urandom));
      end
      tick(1);
    end
    starve_on = 0;

    // Random with a flapping full flag: invariants only.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack_s[i] && $urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
        set_din(i, W'($urandom));
      end
      fifo_full = ($urandom_range(0, 1) == 1);
      tick(1);
    end
    req = '0; fifo_full = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4: number of producers sharing the FIFO write port.
REQ-003 The block SHALL have parameter BURST, default 4: maximum writes per grant.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: per-producer request; each bit is held high while that producer has a word to push.
REQ-007 The block SHALL have port din, input, NREQ*WIDTH bits: producer i's word is din[i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port ack, output, NREQ bits: one-cycle pulse; the word on producer i's din slice is accepted this cycle.
REQ-009 The block SHALL have port grant, output, NREQ bits: one-hot current owner, or zero when idle.
REQ-010 The block SHALL have port fifo_full, input, 1 bit: full flag from the shared FIFO.
REQ-011 The block SHALL have port fifo_wen, output, 1 bit: write enable to the FIFO.
REQ-012 The block SHALL have port fifo_din, output, WIDTH bits: write data to the FIFO.

Function
REQ-013 The FSM SHALL have two states, IDLE and GRANT, plus registers owner (index), last (index of the previous owner) and cnt (0..BURST).
REQ-014 In IDLE with req != 0, the block SHALL select the first requester with req set, searching cyclically from last+1 (round-robin), load owner and last with that index, clear cnt and enter GRANT on the next edge.
REQ-015 In IDLE with req == 0, the block SHALL remain in IDLE; grant SHALL be 0.
REQ-016 In GRANT, grant SHALL equal one-hot(owner).
REQ-017 In GRANT, fifo_wen SHALL equal req[owner] AND NOT fifo_full, combinationally.
REQ-018 In GRANT, ack[owner] SHALL equal fifo_wen; all other ack bits SHALL be 0.
REQ-019 fifo_din SHALL equal the din slice of owner in GRANT and 0 in IDLE.
REQ-020 Each cycle with fifo_wen=1, cnt SHALL increment by 1.
REQ-021 The block SHALL return from GRANT to IDLE on the edge after the cycle in which either req[owner]=0, or fifo_wen=1 with cnt==BURST-1.
REQ-022 While fifo_full=1 and req[owner]=1, the block SHALL hold GRANT with cnt frozen and fifo_wen=0; a full FIFO SHALL never end a grant.
REQ-023 The block SHALL insert exactly one IDLE cycle between consecutive grants, even to the same requester.
REQ-024 If only the previous owner requests, the block SHALL grant it again after the IDLE cycle.
REQ-025 Request-to-first-write latency SHALL be 1 cycle: req rising in an IDLE cycle n gives fifo_wen in cycle n+1 when the FIFO is not full.
REQ-026 Requests arriving or dropping on non-owner bits during GRANT SHALL have no effect until the next IDLE cycle.
REQ-027 The block SHALL never assert fifo_wen while fifo_full=1, and SHALL never assert more than one ack bit in a cycle.

Reset
REQ-028 While rst=1, regardless of clk, the block SHALL be in IDLE with owner=0, last=NREQ-1 (producer 0 has first priority), cnt=0, and grant, ack, fifo_wen and fifo_din all 0.
REQ-029 An assertion of rst during GRANT SHALL abort the burst immediately, with no partial write after rst rises.
REQ-030 After rst falls, the first arbitration SHALL occur on the first clk edge.

Verification
REQ-031 Reset, then req=4'b0001 with din0=8'hA5 held for 6 cycles, fifo_full=0 -> grant=0001 from cycle 1; fifo_wen/ack[0] high for 4 cycles; one IDLE cycle; re-grant to 0.
REQ-032 req=4'b1111 held, fifo_full=0 -> grant order 0,1,2,3,0; each grant gives 4 writes followed by 1 IDLE cycle; fifo_din shows the matching slice.
REQ-033 Owner 2 granted, fifo_full=1 for 3 cycles mid-burst -> fifo_wen=0 and cnt held; the burst completes with 4 total writes after full clears.
REQ-034 Owner 1 drops req after 2 writes -> IDLE on the next edge; the next grant goes to the next requesting index after 1.
REQ-035 rst asserted asynchronously mid-burst between edges -> fifo_wen, ack and grant go to 0 immediately; after release, req=1000 gives producer 3 the grant on the first edge.
REQ-036 Over all random scenarios, the bench SHALL check that there is no fifo_wen while fifo_full=1, that ack is one-hot or zero, and that no producer is starved beyond (NREQ-1)*(BURST+1) cycles while requesting.
